// File: rtl/ex_mc_ctrl_pkg.sv
// Shared definitions for the EX-stage multi-cycle controller: opcodes, reset
// level, state encoding and the captured divide context.
package ex_mc_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned HILO_W    = 2 * DATA_W;
    localparam int unsigned ALUOP_W   = 8;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned DIV_W     = 2 * DATA_W + 1;
    localparam int unsigned DIV_STEPS = DATA_W;

    localparam logic              RST_ENABLE = 1'b1;
    localparam logic [DATA_W-1:0] ZERO_WORD  = '0;

    localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MACC     = 3'd1,
        ST_DIV_ON   = 3'd2,
        ST_DIV_ZERO = 3'd3,
        ST_DIV_END  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OPC_NONE     = 2'd0,
        OPC_MACC_ADD = 2'd1,
        OPC_MACC_SUB = 2'd2,
        OPC_DIV      = 2'd3
    } op_class_e;

    // Everything the divide needs after the operand buses are released
    typedef struct packed {
        logic              neg_quot;
        logic              neg_rem;
        logic [DATA_W-1:0] divisor;
    } div_ctx_t;

    function automatic op_class_e classify(input logic [ALUOP_W-1:0] op);
        unique case (op)
            EXE_MADD_OP, EXE_MADDU_OP: return OPC_MACC_ADD;
            EXE_MSUB_OP, EXE_MSUBU_OP: return OPC_MACC_SUB;
            EXE_DIV_OP,  EXE_DIVU_OP:  return OPC_DIV;
            default:                   return OPC_NONE;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? DATA_W'(-v) : v;
    endfunction

endpackage

// File: rtl/ex_mc_ctrl_div_step.sv
// One restoring shift-subtract step. Register layout: [64:33] partial
// remainder, [32:1] remaining dividend bits, low bits collect the quotient.
module div_step
    import ex_mc_ctrl_pkg::*;
(
    input  logic [DIV_W-1:0]  dr_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DIV_W-1:0]  dr_next_c
);

    logic [DATA_W:0]   top;
    logic [DATA_W-1:0] diff;

    // top is 33 bits so a remainder above 2^31 shifted left is not truncated
    always_comb begin
        top  = dr_in[DIV_W-1:DATA_W];
        diff = top[DATA_W-1:0] - divisor;
        if (top >= {1'b0, divisor}) begin
            dr_next_c = {diff, dr_in[DATA_W-1:0], 1'b1};
        end else begin
            dr_next_c = {dr_in[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_mc_ctrl.sv
// EX-stage multi-cycle controller: multiply-accumulate into HI/LO and a
// 32-step restoring divider, with pipeline stall, flush and result strobe.
module ex_mc_ctrl
    import ex_mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [DATA_W-1:0]  reg1_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  logic [HILO_W-1:0]  mulres_i,
    input  logic [DATA_W-1:0]  hi_i,
    input  logic [DATA_W-1:0]  lo_i,
    input  logic               annul_i,
    output logic               stallreq_o,
    output logic [HILO_W-1:0]  hilo_o,
    output logic               valid_o,
    output logic               busy_o
);

    state_e            state;
    logic [HILO_W-1:0] temp;
    logic [CNT_W-1:0]  cnt;
    logic [DIV_W-1:0]  dreg;
    logic [DIV_W-1:0]  dreg_step;
    div_ctx_t          ctx;

    op_class_e         op_class;
    logic              is_signed_div;
    logic              dividend_neg;
    logic              divisor_neg;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    div_step u_div_step (
        .dr_in     (dreg),
        .divisor   (ctx.divisor),
        .dr_next_c (dreg_step)
    );

    // Operand decode used only at issue time from IDLE
    always_comb begin
        op_class      = classify(aluop_i);
        is_signed_div = (aluop_i == EXE_DIV_OP);
        dividend_neg  = is_signed_div & reg1_i[DATA_W-1];
        divisor_neg   = is_signed_div & reg2_i[DATA_W-1];
        quot_fix      = neg_if(ctx.neg_quot, dreg[DATA_W-1:0]);
        rem_fix       = neg_if(ctx.neg_rem, dreg[DIV_W-1:DATA_W+1]);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= ST_IDLE;
            temp  <= '0;
            cnt   <= '0;
            dreg  <= '0;
            ctx   <= '0;
        end else if (annul_i) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    unique case (op_class)
                        OPC_MACC_ADD: begin
                            temp  <= mulres_i;
                            state <= ST_MACC;
                        end
                        OPC_MACC_SUB: begin
                            temp  <= HILO_W'(~mulres_i + HILO_W'(1));
                            state <= ST_MACC;
                        end
                        OPC_DIV: begin
                            if (reg2_i == ZERO_WORD) begin
                                state <= ST_DIV_ZERO;
                            end else begin
                                dreg  <= {ZERO_WORD, neg_if(dividend_neg, reg1_i), 1'b0};
                                ctx   <= '{neg_quot: dividend_neg ^ divisor_neg,
                                           neg_rem:  dividend_neg,
                                           divisor:  neg_if(divisor_neg, reg2_i)};
                                cnt   <= '0;
                                state <= ST_DIV_ON;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_DIV_ON: begin
                    dreg <= dreg_step;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DIV_STEPS - 1)) begin
                        state <= ST_DIV_END;
                    end
                end
                ST_MACC, ST_DIV_ZERO, ST_DIV_END: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs follow state and live inputs; reset and flush silence them
    always_comb begin
        stallreq_o = 1'b0;
        valid_o    = 1'b0;
        hilo_o     = '0;
        busy_o     = (rst != RST_ENABLE) && (state != ST_IDLE);
        if ((rst != RST_ENABLE) && !annul_i) begin
            unique case (state)
                ST_IDLE:     stallreq_o = (op_class != OPC_NONE);
                ST_MACC: begin
                    hilo_o  = temp + {hi_i, lo_i};
                    valid_o = 1'b1;
                end
                ST_DIV_ON:   stallreq_o = 1'b1;
                ST_DIV_ZERO: valid_o = 1'b1;
                ST_DIV_END: begin
                    hilo_o  = {rem_fix, quot_fix};
                    valid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Randomized self-checking bench for ex_mc_ctrl against an arithmetic model.
module tb_ex_mc_ctrl;
    import ex_mc_ctrl_pkg::*;

    logic               clk;
    logic               rst;
    logic [ALUOP_W-1:0] aluop_i;
    logic [DATA_W-1:0]  reg1_i;
    logic [DATA_W-1:0]  reg2_i;
    logic [HILO_W-1:0]  mulres_i;
    logic [DATA_W-1:0]  hi_i;
    logic [DATA_W-1:0]  lo_i;
    logic               annul_i;
    logic               stallreq_o;
    logic [HILO_W-1:0]  hilo_o;
    logic               valid_o;
    logic               busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [ALUOP_W-1:0] NOP_OP = 8'h00;

    ex_mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .mulres_i   (mulres_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .hilo_o     (hilo_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // Expected result and cycles-to-valid straight from the arithmetic rules
    function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] mul, input logic [63:0] hl,
                                  output logic [63:0] res, output int lat);
        longint sa, sb, q, r;
        res = 64'd0;
        lat = 1;
        if (op == EXE_MADD_OP || op == EXE_MADDU_OP) begin
            res = hl + mul;
        end else if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) begin
            res = hl - mul;
        end else if (b != 32'd0) begin
            lat = 33;
            if (op == EXE_DIVU_OP) begin
                res = {a % b, a / b};
            end else begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
        end
    endfunction

    // Issue one op, scramble operands after issue, check latency and result
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] mul, input logic [63:0] hl);
        logic [63:0] want;
        int          lat, cyc, stalls;
        bit          seen;
        model(op, a, b, mul, hl, want, lat);
        @(posedge clk); #2;
        aluop_i = op; reg1_i = a; reg2_i = b; mulres_i = mul; {hi_i, lo_i} = hl;
        #1;
        cyc = 0; stalls = 0; seen = 0;
        while (cyc < 100) begin
            if (valid_o) begin
                seen = 1;
                break;
            end
            if (stallreq_o) stalls++;
            @(posedge clk); #2;
            aluop_i  = 8'($urandom);
            reg1_i   = $urandom;
            reg2_i   = $urandom;
            mulres_i = {$urandom, $urandom};
            #1;
            cyc++;
        end
        check({tag, "_valid"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_stalls"}, 64'(stalls), 64'(lat));
        check({tag, "_hilo"}, hilo_o, want);
        check({tag, "_end_flags"}, {61'd0, stallreq_o, busy_o, valid_o}, 64'd3);
        @(posedge clk); #2;
        aluop_i = NOP_OP;
        #1;
        check({tag, "_idle_flags"}, {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);
        check({tag, "_idle_hilo"}, hilo_o, 64'd0);
    endtask

    localparam int unsigned N_OPS = 6;
    logic [7:0] ops [N_OPS] = '{EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP,
                                EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP};

    initial begin
        logic [31:0] a, b;
        rst = 1'b1; annul_i = 1'b0; aluop_i = EXE_DIVU_OP;
        reg1_i = 32'd100; reg2_i = 32'd7; mulres_i = '0; hi_i = '0; lo_i = '0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_flags", {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);
        check("reset_hilo", hilo_o, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0; aluop_i = NOP_OP;
        #1;
        check("post_reset_idle", {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);

        run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 64'd0, 64'd0);
        run_op("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'd0);
        run_op("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 64'd0, 64'd0);
        run_op("divu_by0", EXE_DIVU_OP, 32'd5, 32'd0, 64'd0, 64'd0);
        run_op("div_by0", EXE_DIV_OP, 32'hDEAD_BEEF, 32'd0, 64'd0, 64'd0);
        run_op("madd_5_6", EXE_MADD_OP, 32'd0, 32'd0, 64'h6, 64'h5);
        run_op("msub_5_6", EXE_MSUB_OP, 32'd0, 32'd0, 64'h6, 64'h5);
        run_op("divu_big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'd0, 64'd0);
        run_op("div_minint", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'd0);

        // Flush in the 10th DIV_ON cycle, then a fresh divide
        @(posedge clk); #2;
        aluop_i = EXE_DIVU_OP; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (9) begin
            @(posedge clk); #2;
            aluop_i = 8'($urandom);
        end
        @(posedge clk); #2;
        annul_i = 1'b1;
        #1;
        check("annul_same_cycle", {62'd0, stallreq_o, valid_o}, 64'd0);
        @(posedge clk); #2;
        annul_i = 1'b0; aluop_i = NOP_OP;
        #1;
        check("annul_next_idle", {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);
        run_op("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 64'd0, 64'd0);

        // Reset mid-division, then a normal MADDU
        @(posedge clk); #2;
        aluop_i = EXE_DIV_OP; reg1_i = 32'h1234_5678; reg2_i = 32'd17;
        repeat (14) begin
            @(posedge clk); #2;
            aluop_i = NOP_OP;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);
        check("rst_mid_hilo", hilo_o, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0; aluop_i = NOP_OP;
        #1;
        check("rst_mid_after", {61'd0, stallreq_o, busy_o, valid_o}, 64'd0);
        run_op("maddu_after_rst", EXE_MADDU_OP, 32'd0, 32'd0,
               64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, N_OPS - 1)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = -b;
            run_op($sformatf("rand%0d", i), op, a, b, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
